// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, one bit per cycle, stalling the pipeline through busy_o.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [1:0]      dbg_state_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     opb_q;
  logic [2:0]          op_q;
  logic                neg_res_q;
  logic                neg_a_q;
  logic [XLEN-1:0]     result_q;

  // Operand decode for the instruction presented in IDLE
  logic            a_signed, b_signed, sa, sb, is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    a_signed    = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    b_signed    = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    sa          = a_signed & rs1_i[XLEN-1];
    sb          = b_signed & rs2_i[XLEN-1];
    mag_a       = sa ? -rs1_i : rs1_i;
    mag_b       = sb ? -rs2_i : rs2_i;
    is_div      = op_i[2];
    div_zero    = (rs2_i == '0);
    div_ovf     = is_div && !op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
    special     = is_div && (div_zero || div_ovf);
    // REM/REMU select on op_i[1]; divide-by-zero wins over overflow
    if (op_i[1]) special_res = div_zero ? rs1_i : '0;
    else         special_res = div_zero ? '1 : MIN_NEG;
  end

  // One iteration of either datapath, plus the sign fix applied on the final edge
  logic [XLEN:0]     mul_sum, div_shl, div_diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, prod;
  logic [XLEN-1:0]   quo, rem, fin_res;
  logic              last_iter;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    mul_nxt  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    div_shl  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_shl - {1'b0, opb_q};
    div_nxt  = div_diff[XLEN] ? {div_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_nxt  = (state_q == DIV) ? div_nxt : mul_nxt;
    prod     = neg_res_q ? -acc_nxt : acc_nxt;
    quo      = neg_res_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem      = neg_a_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fin_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quo;
      default:                fin_res = rem;
    endcase
    last_iter = (cnt_q == CW'(XLEN-1));
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          busy_o  = 1'b1;
          state_d = special ? DONE : (is_div ? DIV : MUL);
        end
      end
      MUL, DIV: begin
        busy_o = 1'b1;
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i || rst_i) begin
      state_d = IDLE;
      busy_o  = 1'b0;
      done_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_i && !flush_i) begin
            // Low half holds the multiplier or the dividend; opb is multiplicand or divisor
            op_q      <= op_i;
            neg_res_q <= sa ^ sb;
            neg_a_q   <= sa;
            cnt_q     <= '0;
            opb_q     <= mag_b;
            acc_q     <= {{XLEN{1'b0}}, mag_a};
            if (special) result_q <= special_res;
          end
        end
        MUL, DIV: begin
          if (!flush_i) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (last_iter) result_q <= fin_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o    = result_q;
  assign dbg_state_o = state_q;

endmodule
